// File: rtl/func_div.sv
// func_div: sequential restoring divider, dividend / divisor -> quotient, remainder.
// One quotient bit is produced per clock, MSB first, with a start/busy/done handshake.
// Results drive active-low 7-segment codes for the board display.
// Optional build macro FUNC_DIV_BCD_EN: show the quotient in decimal on HEX2:HEX1:HEX0
// through a registered binary-to-BCD stage. Without it, HEX1/HEX0 show the quotient
// as hex nibbles and HEX2 is blank.
module func_div #(
    parameter int DW = 7,
    parameter int VW = 3
) (
    input  logic          CLOCK_50,
    input  logic          RST,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic [7:0]    HEX4,
    output logic [7:0]    HEX2,
    output logic [7:0]    HEX1,
    output logic [7:0]    HEX0
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] dvd_sh;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem_acc;
    logic [DW-1:0] quo_acc;
    logic [CW-1:0] bit_cnt;

    logic          accept;
    logic          zero_div;
    logic          last_step;
    logic [VW:0]   partial;
    logic          take;
    logic [VW-1:0] diff;
    logic [VW-1:0] rem_step;
    logic [DW-1:0] quo_step;

    // Start is honoured only when no division is in flight.
    assign accept    = start && (state != RUN);
    assign zero_div  = (divisor == '0);
    assign last_step = (state == RUN) && (bit_cnt == CW'(DW - 1));
    assign busy      = (state == RUN);

    // One restoring step: bring down the next dividend bit and subtract if it fits.
    // Since rem_acc < dvs, the difference always fits in VW bits, so the
    // subtraction only needs the low VW bits of the partial remainder.
    assign partial  = {rem_acc, dvd_sh[DW-1]};
    assign take     = (partial >= {1'b0, dvs});
    assign diff     = partial[VW-1:0] - dvs;
    assign rem_step = take ? diff : partial[VW-1:0];
    assign quo_step = {quo_acc[DW-2:0], take};

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor skips straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers; results move only on DONE entry.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            dvd_sh      <= '0;
            dvs         <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            bit_cnt     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        dvd_sh      <= dividend;
                        dvs         <= divisor;
                        rem_acc     <= '0;
                        quo_acc     <= '0;
                        bit_cnt     <= '0;
                        div_by_zero <= 1'b0;
                        if (zero_div) begin
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                        end
                    end
                end
                RUN: begin
                    dvd_sh  <= dvd_sh << 1;
                    rem_acc <= rem_step;
                    quo_acc <= quo_step;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_step) begin
                        quotient  <= quo_step;
                        remainder <= rem_step;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    // Active-low segment encoder, decimal point always off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [3:0] rem_nib;
    assign rem_nib = 4'(remainder);
    assign HEX4    = seg7(rem_nib);

`ifdef FUNC_DIV_BCD_EN
    // Shift-and-add-3 conversion of the quotient into three BCD digits.
    function automatic logic [11:0] to_bcd(input logic [DW-1:0] bin);
        logic [11:0] b;
        b = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
            if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
            if (b[11:8] >= 4'd5) b[11:8] = b[11:8] + 4'd3;
            b = {b[10:0], bin[i]};
        end
        return b;
    endfunction

    logic [11:0] bcd_reg;

    // Capture the decimal form during the cycle done is high, so it shows one cycle later.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            bcd_reg <= '0;
        end else if (done) begin
            bcd_reg <= to_bcd(quotient);
        end
    end

    assign HEX2 = (bcd_reg[11:8] == 4'd0) ? 8'hFF : seg7(bcd_reg[11:8]);
    assign HEX1 = seg7(bcd_reg[7:4]);
    assign HEX0 = seg7(bcd_reg[3:0]);
`else
    logic [7:0] quo_byte;
    assign quo_byte = 8'(quotient);
    assign HEX2     = 8'hFF;
    assign HEX1     = seg7(quo_byte[7:4]);
    assign HEX0     = seg7(quo_byte[3:0]);
`endif

endmodule
